// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
//
// Byte-wide boot-load stream feeding the instruction memory loader.
//
// Signals:
//   ld_start  single-cycle pulse that begins a new program load
//   ld_valid  ld_data carries a valid program byte
//   ld_data   program byte, most significant byte of each word first
//   ld_last   marks the final byte of the program
//   ld_ready  loader accepts a byte this cycle
//
// Modports:
//   master  the program source (drives start/valid/data/last)
//   slave   the loader (drives ready)
// ---------------------------------------------------------------------------
interface instr_mem_loader_if;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;

  modport master (
    output ld_start,
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_start,
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//
// Instruction memory for the single-cycle processor's fetch port, together
// with the boot-load path that fills it. While a program is streamed in, the
// processor is held in reset; it is released once a complete program (a
// whole number of 32-bit words ending on a byte tagged ld_last) has arrived.
//
// Parameters:
//   DEPTH   number of 32-bit instruction words (must equal 2**ADDR_W)
//   ADDR_W  word-index width
//
// Ports:
//   clk           single clock, rising-edge
//   reset_n       asynchronous active-low reset
//   PC            processor byte address; low two bits and bits above the
//                 word index are ignored, so fetches wrap modulo DEPTH
//   instr         fetched instruction (zero-latency), 0 unless running
//   ld            byte stream (slave side), see instr_mem_loader_if
//   cpu_reset_n   registered active-low reset to the processor
//   busy          high while a load is in progress
//   ld_err        sticky load error, cleared by the next ld_start
//   words_loaded  complete words written during the current load
// ---------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              PC,
  output logic [31:0]              instr,
  instr_mem_loader_if.slave        ld,
  output logic                     cpu_reset_n,
  output logic                     busy,
  output logic                     ld_err,
  output logic [ADDR_W:0]          words_loaded
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    ERR
  } state_t;

  state_t            state;
  logic              ld_ready_q;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_reg;
  logic [ADDR_W-1:0] wptr;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              full;
  logic              word_done;
  logic              mem_we;
  logic [ADDR_W-1:0] fetch_idx;
  logic              pc_unused;

  // A byte only counts when the stream offers it and we are advertising
  // ready; ld_ready is high exactly while in LOAD, so this also implies LOAD.
  // "full" means the whole array has already been written during this load,
  // so any further byte is an overflow rather than data.
  assign ld.ld_ready = ld_ready_q;
  assign accept      = ld.ld_valid && ld_ready_q;
  assign full        = (words_loaded == (ADDR_W+1)'(DEPTH));
  assign word_done   = (byte_cnt == 2'd3);
  assign mem_we      = (state == LOAD) && accept && !full && word_done;

  // Word index of the fetch; the byte offset and upper PC bits are dropped
  // on purpose so that fetch addresses wrap around the array.
  assign fetch_idx = PC[ADDR_W+1:2];
  assign pc_unused = ^{PC[31:ADDR_W+2], PC[1:0]};

  // Zero-latency fetch. Outside RUN the processor sees a nop so that nothing
  // half-loaded or stale can ever be executed.
  always_comb begin
    instr = '0;
    if (state == RUN) begin
      instr = mem[fetch_idx];
    end
  end

  // Memory write port. The last byte of a word is combined with the three
  // earlier bytes held in the assembly register and written in one go, so a
  // word is never visible half-written. The array itself is never reset,
  // which lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wptr] <= {asm_reg, ld.ld_data};
    end
  end

  // Load controller. All outputs are registered alongside the state so that
  // cpu_reset_n in particular is driven straight from a flop and cannot
  // glitch. IDLE, RUN and ERR all respond to ld_start identically: begin a
  // fresh load from word 0, hold the processor in reset and clear the error.
  // In LOAD, ld_start is ignored and only accepted bytes change anything, so
  // a stalled stream simply leaves everything where it is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ld_ready_q   <= 1'b0;
      cpu_reset_n  <= 1'b0;
      busy         <= 1'b0;
      ld_err       <= 1'b0;
      words_loaded <= '0;
      byte_cnt     <= '0;
      asm_reg      <= '0;
      wptr         <= '0;
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (ld.ld_start) begin
            state        <= LOAD;
            ld_ready_q   <= 1'b1;
            busy         <= 1'b1;
            cpu_reset_n  <= 1'b0;
            ld_err       <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            asm_reg      <= '0;
            wptr         <= '0;
          end
        end

        LOAD: begin
          if (accept) begin
            if (full) begin
              // No room left: the byte is dropped and the load aborts.
              state      <= ERR;
              ld_ready_q <= 1'b0;
              busy       <= 1'b0;
              ld_err     <= 1'b1;
            end else if (word_done) begin
              // Fourth byte completes a word (written by the memory port).
              wptr         <= wptr + ADDR_W'(1);
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
              byte_cnt     <= '0;
              if (ld.ld_last) begin
                state       <= RUN;
                ld_ready_q  <= 1'b0;
                busy        <= 1'b0;
                cpu_reset_n <= 1'b1;
              end
            end else begin
              // Bytes 0-2 shift in MSB-first; after three of them the
              // register holds the upper 24 bits of the word.
              asm_reg  <= {asm_reg[15:0], ld.ld_data};
              byte_cnt <= byte_cnt + 2'd1;
              if (ld.ld_last) begin
                // Program ended mid-word: the partial word is discarded.
                state      <= ERR;
                ld_ready_q <= 1'b0;
                busy       <= 1'b0;
                ld_err     <= 1'b1;
              end
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
